// File: rtl/agc_pkg.sv
// Shared opcode and sequencer-state encodings for the AGC sequencer core.
package agc_pkg;

    localparam int OP_W = 3;
    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_TC   = 3'd0;
    localparam opcode_t OP_CA   = 3'd1;
    localparam opcode_t OP_CS   = 3'd2;
    localparam opcode_t OP_AD   = 3'd3;
    localparam opcode_t OP_MASK = 3'd4;
    localparam opcode_t OP_TS   = 3'd5;
    localparam opcode_t OP_XCH  = 3'd6;
    localparam opcode_t OP_INCR = 3'd7;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_HALT   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_DECODE = 3'd2;
    localparam state_t S_READ   = 3'd3;
    localparam state_t S_WRITE  = 3'd4;

endpackage

// File: rtl/agc_oc_adder.sv
// Ones'-complement adder with end-around carry and signed-overflow detection.
module agc_oc_adder #(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    output logic [WORD_W-1:0] sum_o,
    output logic              ovf_o
);

    logic [WORD_W:0] rawSum;

    // The carry out of the raw sum is folded back into bit 0; the folded add cannot carry again.
    assign rawSum = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o  = rawSum[WORD_W-1:0] + WORD_W'(rawSum[WORD_W]);
    assign ovf_o  = (a_i[WORD_W-1] == b_i[WORD_W-1]) && (sum_o[WORD_W-1] != a_i[WORD_W-1]);

endmodule

// File: rtl/agc_seq_core.sv
// Fetch/decode/execute sequencer around the A/Q/Z/B/G datapath with a req/ack memory port.
// Defining AGC_RETIRE_TRACE_EN adds the retire_valid/retire_pc/retire_op trace outputs.
module agc_seq_core
    import agc_pkg::*;
#(
    parameter int                WORD_W   = 16,
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              halted,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [WORD_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] q,
    output logic              ovf
`ifdef AGC_RETIRE_TRACE_EN
    ,
    output logic              retire_valid,
    output logic [ADDR_W-1:0] retire_pc,
    output logic [OP_W-1:0]   retire_op
`endif
);

    state_t            state_q,  state_d;
    logic [WORD_W-1:0] a_q,      a_d;
    logic [ADDR_W-1:0] qReg_q,   qReg_d;
    logic [ADDR_W-1:0] z_q,      z_d;
    opcode_t           bOp_q,    bOp_d;
    logic [ADDR_W-1:0] bAddr_q,  bAddr_d;
    logic [WORD_W-1:0] g_q,      g_d;
    logic              ovf_q,    ovf_d;
    logic              memReq_q, memReq_d;
    logic              memWe_q,  memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [WORD_W-1:0] memWdata_q, memWdata_d;

    logic              ack;
    logic              retire;
    logic [WORD_W-1:0] addA;
    logic [WORD_W-1:0] addB;
    logic [WORD_W-1:0] addSum;
    logic              addOvf;

    // B keeps only the fields the sequencer uses: opcode and operand address K.
    assign ack  = memReq_q & mem_ack;
    assign addA = (bOp_q == OP_INCR) ? mem_rdata : a_q;
    assign addB = (bOp_q == OP_INCR) ? WORD_W'(1) : mem_rdata;

    agc_oc_adder #(
        .WORD_W(WORD_W)
    ) uAdder (
        .a_i  (addA),
        .b_i  (addB),
        .sum_o(addSum),
        .ovf_o(addOvf)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        qReg_d   = qReg_q;
        z_d      = z_q;
        bOp_d    = bOp_q;
        bAddr_d  = bAddr_q;
        g_d      = g_q;
        ovf_d    = ovf_q;
        retire   = 1'b0;

        case (state_q)
            S_HALT: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ack) begin
                    bOp_d   = mem_rdata[WORD_W-1 -: OP_W];
                    bAddr_d = mem_rdata[ADDR_W-1:0];
                    z_d     = z_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bOp_q)
                    OP_TC: begin
                        qReg_d = z_q;
                        z_d    = bAddr_q;
                        retire = 1'b1;
                    end
                    OP_TS: begin
                        g_d     = a_q;
                        state_d = S_WRITE;
                    end
                    default: state_d = S_READ;
                endcase
            end
            S_READ: begin
                if (ack) begin
                    case (bOp_q)
                        OP_CA: begin
                            a_d    = mem_rdata;
                            retire = 1'b1;
                        end
                        OP_CS: begin
                            a_d    = ~mem_rdata;
                            retire = 1'b1;
                        end
                        OP_AD: begin
                            a_d    = addSum;
                            ovf_d  = ovf_q | addOvf;
                            retire = 1'b1;
                        end
                        OP_MASK: begin
                            a_d    = a_q & mem_rdata;
                            retire = 1'b1;
                        end
                        OP_XCH: begin
                            g_d     = a_q;
                            a_d     = mem_rdata;
                            state_d = S_WRITE;
                        end
                        OP_INCR: begin
                            g_d     = addSum;
                            ovf_d   = ovf_q | addOvf;
                            state_d = S_WRITE;
                        end
                        default: retire = 1'b1;
                    endcase
                end
            end
            S_WRITE: begin
                if (ack) begin
                    retire = 1'b1;
                end
            end
            default: state_d = S_HALT;
        endcase

        if (retire) begin
            state_d = run ? S_FETCH : S_HALT;
        end
    end

    // Memory outputs are registered from next-state values so a request starts with its state and holds until ack.
    always_comb begin
        memReq_d   = (state_d == S_FETCH) || (state_d == S_READ) || (state_d == S_WRITE);
        memWe_d    = (state_d == S_WRITE);
        memAddr_d  = (state_d == S_FETCH) ? z_d : bAddr_d;
        memWdata_d = g_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HALT;
            a_q        <= '0;
            qReg_q     <= '0;
            z_q        <= RESET_PC;
            bOp_q      <= OP_TC;
            bAddr_q    <= '0;
            g_q        <= '0;
            ovf_q      <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            qReg_q     <= qReg_d;
            z_q        <= z_d;
            bOp_q      <= bOp_d;
            bAddr_q    <= bAddr_d;
            g_q        <= g_d;
            ovf_q      <= ovf_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
        end
    end

    assign halted    = (state_q == S_HALT);
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign acc       = a_q;
    assign pc        = z_q;
    assign q         = qReg_q;
    assign ovf       = ovf_q;

`ifdef AGC_RETIRE_TRACE_EN
    logic [ADDR_W-1:0] fetchPc_q;
    logic              retireValid_q;
    logic [ADDR_W-1:0] retirePc_q;
    opcode_t           retireOp_q;

    // The fetch address is captured before Z increments so the trace reports where the instruction came from.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc_q     <= '0;
            retireValid_q <= 1'b0;
            retirePc_q    <= '0;
            retireOp_q    <= OP_TC;
        end else begin
            if (state_q == S_FETCH && ack) begin
                fetchPc_q <= z_q;
            end
            retireValid_q <= retire;
            if (retire) begin
                retirePc_q <= fetchPc_q;
                retireOp_q <= bOp_q;
            end
        end
    end

    assign retire_valid = retireValid_q;
    assign retire_pc    = retirePc_q;
    assign retire_op    = retireOp_q;
`else
    // Retirement is only visible through the architectural registers in this build.
`endif

endmodule

// File: tb/tb_agc_seq_core.sv
// Directed self-checking bench for agc_seq_core with a req/ack word-memory model.
module tb_agc_seq_core;

    localparam int W  = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          halted;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          mem_ack;
    logic [W-1:0]  acc;
    logic [AW-1:0] pc;
    logic [AW-1:0] q;
    logic          ovf;
`ifdef AGC_RETIRE_TRACE_EN
    logic          retire_valid;
    logic [AW-1:0] retire_pc;
    logic [2:0]    retire_op;
`endif

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic          plEn = 1'b0;
    logic [AW-1:0] plAddr = '0;
    logic [W-1:0]  plData = '0;
    int            ackDelay = 0;
    logic          holdWrites = 1'b0;
    int            waitCnt = 0;
    int            readCnt = 0;
    int            writeCnt = 0;
    logic [AW-1:0] lastRAddr = '0;
    logic [AW-1:0] lastWAddr = '0;
    logic [W-1:0]  lastWData = '0;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    localparam logic [27:0] PROG [0:24] = '{
        28'h0002010, 28'h0016011, 28'h0022012, 28'h0036013, 28'h0040040,
        28'h0050100, 28'h0100005, 28'h0110003, 28'h012FFFE, 28'h0130003,
        28'h0147FFF, 28'h0150001, 28'h0160042, 28'h0171234, 28'h020ABCD,
        28'h0402014, 28'h0416015, 28'h0422016, 28'h0432017, 28'h044C020,
        28'h0450005, 28'h060A061, 28'h0615555, 28'h1000FFF, 28'hFFF0060
    };

    agc_seq_core #(
        .WORD_W  (W),
        .ADDR_W  (AW),
        .RESET_PC(12'h000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .halted   (halted),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .acc      (acc),
        .pc       (pc),
        .q        (q),
        .ovf      (ovf)
`ifdef AGC_RETIRE_TRACE_EN
        ,
        .retire_valid(retire_valid),
        .retire_pc   (retire_pc),
        .retire_op   (retire_op)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: combinational read data, ack after ackDelay waiting cycles, writes can be withheld.
    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (waitCnt >= ackDelay) && !(holdWrites && mem_we);

    always @(posedge clk) begin
        if (plEn) begin
            mem[plAddr] <= plData;
        end
        if (mem_req && mem_ack) begin
            waitCnt <= 0;
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                writeCnt      <= writeCnt + 1;
                lastWAddr     <= mem_addr;
                lastWData     <= mem_wdata;
            end else begin
                readCnt   <= readCnt + 1;
                lastRAddr <= mem_addr;
            end
        end else if (mem_req) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input logic [AW-1:0] a, input logic [W-1:0] d);
        plAddr = a;
        plData = d;
        plEn   = 1'b1;
        @(negedge clk);
        plEn   = 1'b0;
    endtask

    // Pulse run for one cycle so exactly one instruction executes; returns its cycle count.
    task automatic applyStimulus(output int cycles);
        int n;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        n = 1;
        while (!halted && n < 60) begin
            @(negedge clk);
            n++;
        end
        cycles = n - 1;
    endtask

    initial begin
        int cyc;
        int r0;
        int w0;
        int n;
        logic [27:0] entry;
        logic sawReq;

        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset halted", halted, 1);
        checkOutput("reset pc", pc, 12'h000);
        checkOutput("reset acc", acc, 16'h0000);
        checkOutput("reset ovf", ovf, 0);
        checkOutput("reset mem_req", mem_req, 0);
        checkOutput("reset q", q, 12'h000);

        for (int i = 0; i < 25; i++) begin
            entry = PROG[i];
            loadWord(entry[27:16], entry[15:0]);
        end

        $display("[TB] CA/AD basics");
        applyStimulus(cyc);
        checkOutput("CA cycles", cyc, 3);
        checkOutput("CA acc", acc, 16'h0005);
        applyStimulus(cyc);
        checkOutput("AD cycles", cyc, 3);
        checkOutput("AD acc", acc, 16'h0008);
        checkOutput("AD pc", pc, 12'h002);

        $display("[TB] ones' complement add and overflow");
        applyStimulus(cyc);
        checkOutput("CA FFFE", acc, 16'hFFFE);
        applyStimulus(cyc);
        checkOutput("AD end-around acc", acc, 16'h0002);
        checkOutput("AD end-around ovf", ovf, 0);
        applyStimulus(cyc);
        checkOutput("TC cycles", cyc, 2);
        checkOutput("TC pc", pc, 12'h040);
        checkOutput("TC q", q, 12'h005);
        applyStimulus(cyc);
        checkOutput("CA 7FFF", acc, 16'h7FFF);
        applyStimulus(cyc);
        checkOutput("AD ovf acc", acc, 16'h8000);
        checkOutput("AD ovf set", ovf, 1);
        applyStimulus(cyc);
        checkOutput("CA after ovf acc", acc, 16'h0042);
        checkOutput("ovf sticky", ovf, 1);

        $display("[TB] XCH");
        applyStimulus(cyc);
        checkOutput("CA 1234", acc, 16'h1234);
        r0 = readCnt;
        w0 = writeCnt;
        applyStimulus(cyc);
        checkOutput("XCH cycles", cyc, 4);
        checkOutput("XCH acc", acc, 16'hABCD);
        checkOutput("XCH reads", readCnt - r0, 2);
        checkOutput("XCH writes", writeCnt - w0, 1);
        checkOutput("XCH read addr", lastRAddr, 12'h020);
        checkOutput("XCH write addr", lastWAddr, 12'h020);
        checkOutput("XCH write data", lastWData, 16'h1234);
        checkOutput("XCH memory", mem[12'h020], 16'h1234);

        $display("[TB] slow fetch and PC wrap");
        applyStimulus(cyc);
        checkOutput("TC to 005 pc", pc, 12'h005);
        checkOutput("TC to 005 q", q, 12'h046);
        ackDelay = 5;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("wait mem_req", mem_req, 1);
            checkOutput("wait mem_addr", mem_addr, 12'h005);
            checkOutput("wait mem_we", mem_we, 0);
            @(negedge clk);
        end
        ackDelay = 0;
        n = 0;
        while (!halted && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("slow TC halted", halted, 1);
        checkOutput("slow TC pc", pc, 12'h100);
        checkOutput("slow TC q", q, 12'h006);
        applyStimulus(cyc);
        checkOutput("TC FFF pc", pc, 12'hFFF);
        checkOutput("TC FFF q", q, 12'h101);
        applyStimulus(cyc);
        checkOutput("wrap q", q, 12'h000);
        checkOutput("wrap pc", pc, 12'h060);

        $display("[TB] reset during withheld write");
        holdWrites = 1'b1;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("TS write req", mem_req && mem_we, 1);
        checkOutput("TS write addr", mem_addr, 12'h061);
        checkOutput("TS write data", mem_wdata, 16'hABCD);
        repeat (2) @(negedge clk);
        checkOutput("TS held req", mem_req, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        holdWrites = 1'b0;
        checkOutput("abort mem_req", mem_req, 0);
        checkOutput("abort halted", halted, 1);
        checkOutput("abort pc", pc, 12'h000);
        checkOutput("abort acc", acc, 16'h0000);
        checkOutput("abort ovf", ovf, 0);
        checkOutput("abort memory", mem[12'h061], 16'h5555);

        $display("[TB] INCR with run dropped mid-instruction");
        loadWord(12'h000, 16'h0050);
        loadWord(12'h050, 16'hE030);
        loadWord(12'h030, 16'h7FFF);
        applyStimulus(cyc);
        checkOutput("TC 050 pc", pc, 12'h050);
        checkOutput("TC 050 q", q, 12'h001);
        run = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("INCR read req", mem_req, 1);
        checkOutput("INCR read we", mem_we, 0);
        checkOutput("INCR read addr", mem_addr, 12'h030);
        checkOutput("INCR ovf before", ovf, 0);
        run = 1'b0;
        @(negedge clk);
        checkOutput("INCR write we", mem_we, 1);
        checkOutput("INCR write data", mem_wdata, 16'h8000);
        checkOutput("INCR write addr", mem_addr, 12'h030);
        checkOutput("INCR ovf", ovf, 1);
        @(negedge clk);
        checkOutput("INCR halted", halted, 1);
        sawReq = 1'b0;
        repeat (4) begin
            sawReq = sawReq | mem_req;
            @(negedge clk);
        end
        checkOutput("INCR no further req", sawReq, 0);
        checkOutput("INCR memory", mem[12'h030], 16'h8000);
        checkOutput("INCR pc", pc, 12'h051);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
